// File: rtl/riscv_core_dcache_axi_master.sv
// Bridges the data-cache memory port onto a 64-bit AXI4 master: line fills become
// 4-beat INCR reads assembled into one block, stores become single-beat strobed writes.
module riscv_core_dcache_axi_master #(
  parameter int ADDR_WIDTH     = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BLOCK_WIDTH    = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mem_read_req,
  input  logic [ADDR_WIDTH-1:0]     i_mem_read_address,
  output logic                      o_mem_read_done,
  output logic [BLOCK_WIDTH-1:0]    o_block_to_cache,
  input  logic                      i_mem_write_valid,
  input  logic [ADDR_WIDTH-1:0]     i_mem_write_address,
  input  logic [AXI_DATA_WIDTH-1:0] i_mem_write_data,
  input  logic [7:0]                i_mem_write_strobe,
  output logic                      o_mem_write_done,
  output logic                      o_bus_error,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  output logic [ADDR_WIDTH-1:0]     o_awaddr,
  output logic [7:0]                o_awlen,
  output logic [2:0]                o_awsize,
  output logic [1:0]                o_awburst,
  output logic                      o_awvalid,
  input  logic                      i_awready,
  output logic [AXI_DATA_WIDTH-1:0] o_wdata,
  output logic [7:0]                o_wstrb,
  output logic                      o_wlast,
  output logic                      o_wvalid,
  input  logic                      i_wready,
  input  logic [1:0]                i_bresp,
  input  logic                      i_bvalid,
  output logic                      o_bready
);
  localparam int BEATS    = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int BEAT_W   = $clog2(BEATS);
  localparam int FILL_W   = BLOCK_WIDTH - AXI_DATA_WIDTH;
  localparam int LINE_OFS = $clog2(BLOCK_WIDTH / 8);
  localparam int WORD_OFS = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, DONE_RD, WR, WR_RESP, DONE_WR} state_t;

  state_t                    state_reg, state_next;
  logic [ADDR_WIDTH-1:0]     araddr_reg, araddr_next;
  logic [ADDR_WIDTH-1:0]     awaddr_reg, awaddr_next;
  logic [AXI_DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [7:0]                wstrb_reg, wstrb_next;
  logic                      arvalid_reg, arvalid_next;
  logic                      rready_reg, rready_next;
  logic                      awvalid_reg, awvalid_next;
  logic                      wvalid_reg, wvalid_next;
  logic                      bready_reg, bready_next;
  logic [BEAT_W-1:0]         beat_reg, beat_next;
  logic                      err_reg, err_next;
  logic [BLOCK_WIDTH-1:0]    block_reg, block_next;
  logic [FILL_W-1:0]         fill_flat;
  logic                      beat_fire;
  logic                      aw_open, w_open;
  logic                      unused_bits;

  assign beat_fire = (state_reg == RD_DATA) && rready_reg && i_rvalid;
  assign aw_open   = awvalid_reg && !i_awready;
  assign w_open    = wvalid_reg && !i_wready;

  // Beats 0..BEATS-2 wait here; the final beat goes straight into the output block.
  generate
    for (genvar gi = 0; gi < BEATS - 1; gi++) begin : g_lane
      logic [AXI_DATA_WIDTH-1:0] lane_reg;
      always_ff @(posedge i_clk) begin
        if (i_rst)
          lane_reg <= '0;
        else if (beat_fire && beat_reg == BEAT_W'(gi))
          lane_reg <= i_rdata;
      end
      assign fill_flat[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = lane_reg;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      araddr_reg  <= '0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      beat_reg    <= '0;
      err_reg     <= 1'b0;
      block_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      araddr_reg  <= araddr_next;
      awaddr_reg  <= awaddr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      beat_reg    <= beat_next;
      err_reg     <= err_next;
      block_reg   <= block_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    araddr_next  = araddr_reg;
    awaddr_next  = awaddr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;
    beat_next    = beat_reg;
    err_next     = err_reg;
    block_next   = block_reg;
    unique case (state_reg)
      IDLE: begin
        if (i_mem_write_valid) begin
          awaddr_next  = {i_mem_write_address[ADDR_WIDTH-1:WORD_OFS], {WORD_OFS{1'b0}}};
          wdata_next   = i_mem_write_data;
          wstrb_next   = i_mem_write_strobe;
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          err_next     = 1'b0;
          state_next   = WR;
        end else if (i_mem_read_req) begin
          araddr_next  = {i_mem_read_address[ADDR_WIDTH-1:LINE_OFS], {LINE_OFS{1'b0}}};
          arvalid_next = 1'b1;
          err_next     = 1'b0;
          state_next   = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (i_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          beat_next    = '0;
          state_next   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (beat_fire) begin
          beat_next = beat_reg + BEAT_W'(1);
          // rlast must mark exactly the final beat; anything else is a protocol error.
          if (i_rresp[1] || (i_rlast != (beat_reg == LAST_BEAT)))
            err_next = 1'b1;
          if (beat_reg == LAST_BEAT) begin
            rready_next = 1'b0;
            block_next  = {i_rdata, fill_flat};
            state_next  = DONE_RD;
          end
        end
      end
      WR: begin
        if (awvalid_reg && i_awready) awvalid_next = 1'b0;
        if (wvalid_reg && i_wready)   wvalid_next  = 1'b0;
        if (!aw_open && !w_open) begin
          bready_next = 1'b1;
          state_next  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (i_bvalid) begin
          err_next    = i_bresp[1];
          bready_next = 1'b0;
          state_next  = DONE_WR;
        end
      end
      DONE_RD, DONE_WR: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign o_mem_read_done  = (state_reg == DONE_RD);
  assign o_mem_write_done = (state_reg == DONE_WR);
  assign o_bus_error      = err_reg && (o_mem_read_done || o_mem_write_done);
  assign o_block_to_cache = block_reg;

  assign o_araddr  = araddr_reg;
  assign o_arlen   = 8'd3;
  assign o_arsize  = 3'd3;
  assign o_arburst = 2'b01;
  assign o_arvalid = arvalid_reg;
  assign o_rready  = rready_reg;
  assign o_awaddr  = awaddr_reg;
  assign o_awlen   = 8'd0;
  assign o_awsize  = 3'd3;
  assign o_awburst = 2'b01;
  assign o_awvalid = awvalid_reg;
  assign o_wdata   = wdata_reg;
  assign o_wstrb   = wstrb_reg;
  assign o_wlast   = wvalid_reg;
  assign o_wvalid  = wvalid_reg;
  assign o_bready  = bready_reg;

  // Offset bits and the low response bits carry no information for this bridge.
  assign unused_bits = ^{i_mem_read_address[LINE_OFS-1:0], i_mem_write_address[WORD_OFS-1:0],
                         i_rresp[0], i_bresp[0]};
endmodule

// File: tb/tb_riscv_core_dcache_axi_master.sv
// Bench for the dcache AXI bridge: a vector table of directed and random fills/stores
// played against an AXI slave model, plus hand-written arbitration and reset sequences.
module tb_riscv_core_dcache_axi_master;
  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_mem_read_req = 1'b0;
  logic [63:0]  i_mem_read_address = '0;
  logic         o_mem_read_done;
  logic [255:0] o_block_to_cache;
  logic         i_mem_write_valid = 1'b0;
  logic [63:0]  i_mem_write_address = '0;
  logic [63:0]  i_mem_write_data = '0;
  logic [7:0]   i_mem_write_strobe = '0;
  logic         o_mem_write_done;
  logic         o_bus_error;
  logic [63:0]  o_araddr;
  logic [7:0]   o_arlen;
  logic [2:0]   o_arsize;
  logic [1:0]   o_arburst;
  logic         o_arvalid;
  logic         i_arready = 1'b0;
  logic [63:0]  i_rdata = '0;
  logic [1:0]   i_rresp = '0;
  logic         i_rlast = 1'b0;
  logic         i_rvalid = 1'b0;
  logic         o_rready;
  logic [63:0]  o_awaddr;
  logic [7:0]   o_awlen;
  logic [2:0]   o_awsize;
  logic [1:0]   o_awburst;
  logic         o_awvalid;
  logic         i_awready = 1'b0;
  logic [63:0]  o_wdata;
  logic [7:0]   o_wstrb;
  logic         o_wlast;
  logic         o_wvalid;
  logic         i_wready = 1'b0;
  logic [1:0]   i_bresp = '0;
  logic         i_bvalid = 1'b0;
  logic         o_bready;

  always #5 clk = ~clk;

  riscv_core_dcache_axi_master dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_mem_read_req(i_mem_read_req), .i_mem_read_address(i_mem_read_address),
    .o_mem_read_done(o_mem_read_done), .o_block_to_cache(o_block_to_cache),
    .i_mem_write_valid(i_mem_write_valid), .i_mem_write_address(i_mem_write_address),
    .i_mem_write_data(i_mem_write_data), .i_mem_write_strobe(i_mem_write_strobe),
    .o_mem_write_done(o_mem_write_done), .o_bus_error(o_bus_error),
    .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
    .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .o_rready(o_rready),
    .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  typedef struct {
    bit           is_wr;
    logic [63:0]  addr;
    logic [255:0] rdata;     // beat k in [64k+63:64k]
    logic [7:0]   rresp;     // 2 bits per beat
    logic [3:0]   rlast;     // rlast flag per beat
    int           ar_delay;
    logic [7:0]   rgap;      // idle cycles before each beat, 2 bits per beat
    logic [63:0]  wdata;
    logic [7:0]   wstrb;
    int           aw_delay;
    int           w_delay;
    logic [1:0]   bresp;
    logic [63:0]  exp_addr;
    logic         exp_err;
    logic [255:0] exp_block;
  } vec_t;

  vec_t         vecs[$];
  int           n_tests = 0;
  int           n_fail = 0;
  logic [255:0] last_block = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference rules: line-aligned AR, word-aligned AW, error on any SLVERR/DECERR
  // or when rlast is anywhere other than the fourth beat alone.
  function automatic logic [63:0] model_line(input logic [63:0] a);
    return a - (a % 64'd32);
  endfunction
  function automatic logic [63:0] model_word(input logic [63:0] a);
    return a - (a % 64'd8);
  endfunction
  function automatic logic model_rd_err(input logic [7:0] resp, input logic [3:0] last);
    logic bad = (last != 4'b1000);
    for (int k = 0; k < 4; k++) if (resp[2*k+1]) bad = 1'b1;
    return bad;
  endfunction

  function automatic vec_t mk_read(input logic [63:0] a, input logic [255:0] d,
                                   input logic [7:0] resp, input logic [3:0] last,
                                   input int ard, input logic [7:0] gap);
    vec_t v;
    v.is_wr = 1'b0; v.addr = a; v.rdata = d; v.rresp = resp; v.rlast = last;
    v.ar_delay = ard; v.rgap = gap; v.wdata = '0; v.wstrb = '0;
    v.aw_delay = 0; v.w_delay = 0; v.bresp = '0;
    v.exp_addr = '0; v.exp_err = 1'b0; v.exp_block = '0;
    return v;
  endfunction
  function automatic vec_t mk_write(input logic [63:0] a, input logic [63:0] d,
                                    input logic [7:0] s, input int awd, input int wd,
                                    input logic [1:0] br);
    vec_t v;
    v = mk_read(a, '0, '0, '0, 0, '0);
    v.is_wr = 1'b1; v.wdata = d; v.wstrb = s; v.aw_delay = awd; v.w_delay = wd; v.bresp = br;
    return v;
  endfunction

  task automatic do_reset();
    i_rst = 1'b1; i_mem_read_req = 1'b0; i_mem_write_valid = 1'b0;
    i_arready = 1'b0; i_rvalid = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    last_block = '0;
  endtask

  task automatic run_read(input vec_t v, input bit abort_after_beat1);
    int cyc = 0, b = 0, wait_c = 0, ar_cnt = 0, dones = 0, post = 0;
    bit seen_ar = 1'b0, finished = 1'b0;
    i_mem_read_req = 1'b1;
    i_mem_read_address = v.addr;
    while (!finished && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (abort_after_beat1 && b == 2) begin
        i_rst = 1'b1; i_rvalid = 1'b0; i_rlast = 1'b0; i_arready = 1'b0; i_mem_read_req = 1'b0;
        @(negedge clk);
        chk("rst_handshakes_low", {o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 5'b0);
        chk("rst_no_done", {o_mem_read_done, o_mem_write_done, o_bus_error}, 3'b0);
        chk("rst_block_clear", o_block_to_cache, 256'b0);
        i_rst = 1'b0;
        last_block = '0;
        repeat (4) begin
          @(negedge clk);
          chk("rst_no_late_done", {o_mem_read_done, o_arvalid, o_rready}, 3'b0);
        end
        finished = 1'b1;
      end else begin
        chk("rd_no_wdone", o_mem_write_done, 1'b0);
        if (o_arvalid) begin
          chk("araddr", o_araddr, v.exp_addr);
          if (!seen_ar) chk("ar_consts", {o_arlen, o_arsize, o_arburst}, {8'd3, 3'd3, 2'b01});
          seen_ar = 1'b1;
          i_arready = (ar_cnt >= v.ar_delay);
          ar_cnt++;
        end else begin
          i_arready = 1'b0;
        end
        if (o_rready && b < 4) begin
          if (wait_c < int'(v.rgap[2*b +: 2])) begin
            i_rvalid = 1'b0; i_rlast = 1'b0;
            wait_c++;
          end else begin
            i_rvalid = 1'b1;
            i_rdata = v.rdata[64*b +: 64];
            i_rresp = v.rresp[2*b +: 2];
            i_rlast = v.rlast[b];
            b++;
            wait_c = 0;
          end
        end else begin
          i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00;
        end
        if (o_mem_read_done) begin
          dones++;
          chk("rd_block", o_block_to_cache, v.exp_block);
          chk("rd_err", o_bus_error, v.exp_err);
          i_mem_read_req = 1'b0;
          last_block = v.exp_block;
        end else begin
          chk("block_hold", o_block_to_cache, last_block);
          chk("err_idle", o_bus_error, 1'b0);
        end
        if (dones > 0) begin
          post++;
          if (post == 4) finished = 1'b1;
        end
      end
    end
    i_arready = 1'b0; i_rvalid = 1'b0; i_rlast = 1'b0;
    if (!finished) begin
      chk("read_timeout", finished, 1'b1);
      do_reset();
    end else if (!abort_after_beat1) begin
      chk("read_done_count", dones, 1);
    end
  endtask

  task automatic run_write(input vec_t v, input bit rd_pending);
    int cyc = 0, aw_cnt = 0, w_cnt = 0, dones = 0, post = 0;
    bit aw_hs = 1'b0, w_hs = 1'b0, seen_aw = 1'b0, finished = 1'b0;
    i_mem_write_valid = 1'b1;
    i_mem_write_address = v.addr;
    i_mem_write_data = v.wdata;
    i_mem_write_strobe = v.wstrb;
    while (!finished && cyc < 300) begin
      @(negedge clk);
      cyc++;
      chk("wr_no_rdone", o_mem_read_done, 1'b0);
      if (dones == 0) chk("wr_no_ar", o_arvalid, 1'b0);
      if (o_bready) chk("bready_after_hs", {aw_hs, w_hs}, 2'b11);
      if (o_awvalid) begin
        chk("awaddr", o_awaddr, v.exp_addr);
        if (!seen_aw) chk("aw_consts", {o_awlen, o_awsize, o_awburst}, {8'd0, 3'd3, 2'b01});
        seen_aw = 1'b1;
        i_awready = (aw_cnt >= v.aw_delay);
        if (i_awready) aw_hs = 1'b1;
        aw_cnt++;
      end else begin
        i_awready = 1'b0;
      end
      if (o_wvalid) begin
        chk("w_beat", {o_wdata, o_wstrb, o_wlast}, {v.wdata, v.wstrb, 1'b1});
        i_wready = (w_cnt >= v.w_delay);
        if (i_wready) w_hs = 1'b1;
        w_cnt++;
      end else begin
        i_wready = 1'b0;
      end
      i_bvalid = o_bready;
      i_bresp = o_bready ? v.bresp : 2'b00;
      if (o_mem_write_done) begin
        dones++;
        chk("wr_err", o_bus_error, v.exp_err);
        chk("wr_block_hold", o_block_to_cache, last_block);
        i_mem_write_valid = 1'b0;
      end
      if (dones > 0) begin
        post++;
        if (rd_pending || post == 4) finished = 1'b1;
      end
    end
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
    if (!finished) begin
      chk("write_timeout", finished, 1'b1);
      do_reset();
    end else begin
      chk("write_done_count", dones, 1);
    end
  endtask

  initial begin
    vec_t v;
    logic [63:0] b0, b1, b2, b3;
    b0 = 64'h1111_1111_1111_1111; b1 = 64'h2222_2222_2222_2222;
    b2 = 64'h3333_3333_3333_3333; b3 = 64'h4444_4444_4444_4444;

    // Directed rows with hand-derived expectations.
    v = mk_read(64'h8000_1234, {b3, b2, b1, b0}, 8'h00, 4'b1000, 0, 8'h00);
    v.exp_addr = 64'h8000_1220; v.exp_err = 1'b0; v.exp_block = {b3, b2, b1, b0};
    vecs.push_back(v);
    v = mk_read(64'h4000_00F8, {b0, b1, b2, b3}, 8'h00, 4'b1000, 3, 8'h20);
    v.exp_addr = 64'h4000_00E0; v.exp_err = 1'b0; v.exp_block = {b0, b1, b2, b3};
    vecs.push_back(v);
    v = mk_write(64'h1006, 64'hAABB_0000_0000_0000, 8'hC0, 3, 1, 2'b00);
    v.exp_addr = 64'h1000; v.exp_err = 1'b0;
    vecs.push_back(v);
    v = mk_read(64'h0000_2040, {b3, b3, b0, b0}, 8'h08, 4'b1000, 1, 8'h00);
    v.exp_addr = 64'h0000_2040; v.exp_err = 1'b1; v.exp_block = {b3, b3, b0, b0};
    vecs.push_back(v);
    v = mk_read(64'h0000_3FFF, {b1, b2, b3, b0}, 8'h00, 4'b0100, 0, 8'h00);
    v.exp_addr = 64'h0000_3FE0; v.exp_err = 1'b1; v.exp_block = {b1, b2, b3, b0};
    vecs.push_back(v);
    v = mk_write(64'h0000_5557, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 2'b11);
    v.exp_addr = 64'h0000_5550; v.exp_err = 1'b1;
    vecs.push_back(v);

    // Random rows; expectations come from the reference rules.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = mk_write({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        v.exp_addr = model_word(v.addr);
        v.exp_err = (v.bresp >= 2'd2);
      end else begin
        logic [7:0] resp = '0;
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, 7) == 0) resp[2*k +: 2] = 2'($urandom_range(1, 3));
        v = mk_read({$urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    resp, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b1000,
                    $urandom_range(0, 3), 8'($urandom));
        v.exp_addr = model_line(v.addr);
        v.exp_err = model_rd_err(v.rresp, v.rlast);
        for (int k = 0; k < 4; k++) v.exp_block[64*k +: 64] = v.rdata[64*k +: 64];
      end
      vecs.push_back(v);
    end

    repeat (3) @(negedge clk);
    chk("reset_valids", {o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 5'b0);
    chk("reset_dones", {o_mem_read_done, o_mem_write_done, o_bus_error}, 3'b0);
    chk("reset_block", o_block_to_cache, 256'b0);
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) run_write(vecs[i], 1'b0);
      else               run_read(vecs[i], 1'b0);
      $display("[TB] vec %0d %s addr=%h exp_err=%0b", i, vecs[i].is_wr ? "write" : "read ",
               vecs[i].addr, vecs[i].exp_err);
    end

    // Simultaneous requests: the store goes first, then the held fill is issued.
    v = mk_read(64'h9000_0010, {b2, b0, b3, b1}, 8'h00, 4'b1000, 0, 8'h00);
    v.exp_addr = 64'h9000_0000; v.exp_err = 1'b0; v.exp_block = {b2, b0, b3, b1};
    i_mem_read_req = 1'b1;
    i_mem_read_address = v.addr;
    vecs[0] = mk_write(64'h0000_7003, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1, 0, 2'b00);
    vecs[0].exp_addr = 64'h0000_7000; vecs[0].exp_err = 1'b0;
    run_write(vecs[0], 1'b1);
    run_read(v, 1'b0);
    $display("[TB] simultaneous write-then-read done");

    // Reset after beat 1, then a clean fill.
    v = mk_read(64'hA000_0040, {b0, b0, b1, b1}, 8'h00, 4'b1000, 0, 8'h00);
    v.exp_addr = 64'hA000_0040; v.exp_err = 1'b0; v.exp_block = {b0, b0, b1, b1};
    run_read(v, 1'b1);
    $display("[TB] read aborted by reset after beat 1");
    v = mk_read(64'hA000_0068, {b3, b1, b2, b0}, 8'h00, 4'b1000, 2, 8'h11);
    v.exp_addr = 64'hA000_0060; v.exp_err = 1'b0; v.exp_block = {b3, b1, b2, b0};
    run_read(v, 1'b0);
    $display("[TB] read after reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
